// File: rtl/stage2_frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// stage2_frame_capture_pkg
// Shared definitions for the stage-2 frame capture block: field widths of the
// market-data block, message geometry, FSM state encoding, error codes and
// two small helpers (first-error-wins merge, expected block_size).
// -----------------------------------------------------------------------------
package stage2_frame_capture_pkg;

    // Field widths of the market-data block
    localparam int BLOCK_SIZE_BITS     = 16;
    localparam int SEQ_NUMBER_BITS     = 32;
    localparam int MESSAGE_NUMBER_BITS = 8;
    localparam int TIME_MESSAGE_BITS   = 64;
    localparam int MAX_MESSAGE_BITS    = 280;
    localparam int CHECK_SUM_DATA_BITS = 8;

    // Block geometry
    localparam int MAX_MSGS        = 3;
    localparam int MSG_BYTES       = MAX_MESSAGE_BITS / 8;
    localparam int CHK_BYTES       = CHECK_SUM_DATA_BITS / 8;
    localparam int HDR_BYTES       = 15;
    localparam int BLOCK_SIZE_BASE = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_MSG   = 3'd2,
        ST_CHK   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ERR_OK      = 3'd0,
        ERR_SHORT   = 3'd1,
        ERR_LONG    = 3'd2,
        ERR_MSGCNT  = 3'd3,
        ERR_BLKSIZE = 3'd4
    } err_e;

    // The first error latched for a frame is the one reported.
    function automatic err_e first_err(input err_e cur, input err_e nxt);
        return (cur == ERR_OK) ? nxt : cur;
    endfunction

    // block_size counts everything after the block_size field itself
    // except the trailer: 13 header bytes plus 35 per message.
    function automatic logic [15:0] expected_block_size(input logic [7:0] msg_num);
        return 16'(BLOCK_SIZE_BASE) + 16'(msg_num) * 16'(MSG_BYTES);
    endfunction

endpackage

// File: rtl/stage2_field_shift.sv
// -----------------------------------------------------------------------------
// stage2_field_shift
// Byte-into-field register: places one stream byte into a big-endian byte
// lane of a wide field (lane 0 = MSBs). A clear empties the whole field and
// may coincide with a load, so the first byte of a frame lands in an
// otherwise zero field. Lanes never written stay zero.
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset, clears the field
//   clr_i    in   clear the field (takes effect before the load)
//   load_i   in   write byte_i into lane idx_i
//   idx_i    in   byte lane index, 0 = most significant byte
//   byte_i   in   stream byte
//   field_o  out  captured field
// -----------------------------------------------------------------------------
module stage2_field_shift #(
    parameter int FIELD_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [5:0]         idx_i,
    input  logic [7:0]         byte_i,
    output logic [FIELD_W-1:0] field_o
);

    localparam int NB = FIELD_W / 8;

    logic [FIELD_W-1:0] field_q, field_d;

    always_comb begin
        field_d = clr_i ? '0 : field_q;
        if (load_i) begin
            for (int k = 0; k < NB; k++) begin
                if (idx_i == 6'(k)) begin
                    field_d[FIELD_W-1-8*k -: 8] = byte_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign field_o = field_q;

endmodule

// File: rtl/stage2_frame_capture.sv
// -----------------------------------------------------------------------------
// stage2_frame_capture
// Deframes a byte-serial market-data block into parallel header fields, up to
// three 280-bit messages and the received trailer checksum byte, then holds
// the frame on its outputs until downstream accepts it.
// Wire order: block_size(2) seq(4) msg_number(1) time(8) messages(35 each)
// checksum(1), all big-endian.
//
// Optional build macro: CHK_RUNNING_EN adds an 8-bit running byte sum of the
// header and message bytes (calc_check_sum_data) and a compare flag against
// the received trailer (check_mismatch).
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   in_data/in_valid/in_sop/in_eop    byte stream in
//   in_ready                          low while a frame is being presented
//   block_size_data .. time_message_data   header fields
//   message_1..3                      messages, unused slots zero
//   rx_check_sum_data                 received trailer byte
//   frame_valid/frame_ready           frame handshake
//   frame_err/err_code                error flag and code, valid with frame_valid
//   calc_check_sum_data/check_mismatch    only with CHK_RUNNING_EN
// -----------------------------------------------------------------------------
module stage2_frame_capture
    import stage2_frame_capture_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_sop,
    input  logic         in_eop,
    output logic         in_ready,
    output logic [15:0]  block_size_data,
    output logic [31:0]  seq_number_data,
    output logic [7:0]   message_number_data,
    output logic [63:0]  time_message_data,
    output logic [279:0] message_1,
    output logic [279:0] message_2,
    output logic [279:0] message_3,
    output logic [7:0]   rx_check_sum_data,
    output logic         frame_valid,
    input  logic         frame_ready,
`ifdef CHK_RUNNING_EN
    output logic [7:0]   calc_check_sum_data,
    output logic         check_mismatch,
`endif
    output logic         frame_err,
    output logic [2:0]   err_code
);

    state_e        state_q, state_d;
    err_e          err_q, err_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic          beat;
    logic [1:0]    msg_slots;
    logic          clr_fields;
    logic          ld_blk, ld_seq, ld_num, ld_time, ld_chk;
    logic [MAX_MSGS-1:0] ld_msg;
    logic [5:0]    idx;
    logic [MAX_MESSAGE_BITS-1:0] msg_w [MAX_MSGS];

    assign beat        = in_valid && in_ready;
    assign in_ready    = (state_q != ST_OUT);
    assign frame_valid = (state_q == ST_OUT);
    assign frame_err   = (err_q != ERR_OK);
    assign err_code    = err_q;

    // Oversized message counts still capture, limited to the slots we have.
    assign msg_slots = (message_number_data > 8'(MAX_MSGS)) ? 2'(MAX_MSGS)
                                                            : message_number_data[1:0];

    // -------------------------------------------------------------------------
    // Field capture registers
    // -------------------------------------------------------------------------
    stage2_field_shift #(.FIELD_W(BLOCK_SIZE_BITS)) u_blk (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_fields), .load_i(ld_blk),
        .idx_i(idx), .byte_i(in_data), .field_o(block_size_data));

    stage2_field_shift #(.FIELD_W(SEQ_NUMBER_BITS)) u_seq (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_fields), .load_i(ld_seq),
        .idx_i(idx), .byte_i(in_data), .field_o(seq_number_data));

    stage2_field_shift #(.FIELD_W(MESSAGE_NUMBER_BITS)) u_num (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_fields), .load_i(ld_num),
        .idx_i(idx), .byte_i(in_data), .field_o(message_number_data));

    stage2_field_shift #(.FIELD_W(TIME_MESSAGE_BITS)) u_time (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_fields), .load_i(ld_time),
        .idx_i(idx), .byte_i(in_data), .field_o(time_message_data));

    stage2_field_shift #(.FIELD_W(CHECK_SUM_DATA_BITS)) u_chk (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_fields), .load_i(ld_chk),
        .idx_i(idx), .byte_i(in_data), .field_o(rx_check_sum_data));

    for (genvar g = 0; g < MAX_MSGS; g++) begin : g_msg
        stage2_field_shift #(.FIELD_W(MAX_MESSAGE_BITS)) u_msg (
            .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_fields), .load_i(ld_msg[g]),
            .idx_i(idx), .byte_i(in_data), .field_o(msg_w[g]));
    end

    assign message_1 = msg_w[0];
    assign message_2 = msg_w[1];
    assign message_3 = msg_w[2];

    // -------------------------------------------------------------------------
    // Deframing FSM: next state, counters, error and field write strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        clr_fields = 1'b0;
        ld_blk     = 1'b0;
        ld_seq     = 1'b0;
        ld_num     = 1'b0;
        ld_time    = 1'b0;
        ld_chk     = 1'b0;
        ld_msg     = '0;
        idx        = '0;

        if (beat) begin
            unique case (state_q)
                ST_IDLE: begin
                    // The sop byte is header byte 0; everything else is dropped.
                    if (in_sop) begin
                        clr_fields = 1'b1;
                        err_d      = ERR_OK;
                        ld_blk     = 1'b1;
                        cnt_d      = 6'd1;
                        slot_d     = '0;
                        state_d    = ST_HDR;
                        if (in_eop) begin
                            err_d   = ERR_SHORT;
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_HDR: begin
                    if (in_sop) begin
                        err_d   = first_err(err_q, ERR_SHORT);
                        state_d = ST_OUT;
                    end else begin
                        if (cnt_q < 6'd2) begin
                            ld_blk = 1'b1;
                            idx    = cnt_q;
                        end else if (cnt_q < 6'd6) begin
                            ld_seq = 1'b1;
                            idx    = cnt_q - 6'd2;
                        end else if (cnt_q == 6'd6) begin
                            ld_num = 1'b1;
                            if (in_data > 8'(MAX_MSGS)) begin
                                err_d = first_err(err_d, ERR_MSGCNT);
                            end
                        end else begin
                            ld_time = 1'b1;
                            idx     = cnt_q - 6'd7;
                        end
                        if (cnt_q == 6'(HDR_BYTES - 1)) begin
                            cnt_d   = '0;
                            slot_d  = '0;
                            state_d = (msg_slots == 2'd0) ? ST_CHK : ST_MSG;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                        if (in_eop) begin
                            err_d   = first_err(err_d, ERR_SHORT);
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_MSG: begin
                    if (in_sop) begin
                        err_d   = first_err(err_q, ERR_SHORT);
                        state_d = ST_OUT;
                    end else begin
                        ld_msg = 3'b001 << slot_q;
                        idx    = cnt_q;
                        if (cnt_q == 6'(MSG_BYTES - 1)) begin
                            cnt_d = '0;
                            if (slot_q == msg_slots - 2'd1) begin
                                state_d = ST_CHK;
                            end else begin
                                slot_d = slot_q + 2'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                        if (in_eop) begin
                            err_d   = first_err(err_d, ERR_SHORT);
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_CHK: begin
                    if (in_sop) begin
                        err_d   = first_err(err_q, ERR_SHORT);
                        state_d = ST_OUT;
                    end else begin
                        ld_chk = 1'b1;
                        if (in_eop) begin
                            state_d = ST_OUT;
                        end else begin
                            err_d   = first_err(err_q, ERR_LONG);
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (in_eop) begin
                        state_d = ST_OUT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        if (state_q == ST_OUT && frame_ready) begin
            state_d = ST_IDLE;
        end

        // Header fields are complete by the time a clean frame reaches OUT.
        if (state_q != ST_OUT && state_d == ST_OUT &&
            block_size_data != expected_block_size(message_number_data)) begin
            err_d = first_err(err_d, ERR_BLKSIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

`ifdef CHK_RUNNING_EN
    // -------------------------------------------------------------------------
    // Running mod-256 sum of every captured header and message byte
    // -------------------------------------------------------------------------
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_fields) begin
            sum_d = in_data;
        end else if (ld_blk || ld_seq || ld_num || ld_time || (ld_msg != '0)) begin
            sum_d = sum_q + in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign calc_check_sum_data = sum_q;
    assign check_mismatch      = frame_valid && (sum_q != rx_check_sum_data);
`endif

endmodule

// File: tb/tb_stage2_frame_capture.sv
module tb_stage2_frame_capture;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_sop = 1'b0;
    logic         in_eop = 1'b0;
    logic         in_ready;
    logic [15:0]  block_size_data;
    logic [31:0]  seq_number_data;
    logic [7:0]   message_number_data;
    logic [63:0]  time_message_data;
    logic [279:0] message_1, message_2, message_3;
    logic [7:0]   rx_check_sum_data;
    logic         frame_valid;
    logic         frame_ready = 1'b0;
    logic         frame_err;
    logic [2:0]   err_code;
`ifdef CHK_RUNNING_EN
    logic [7:0]   calc_check_sum_data;
    logic         check_mismatch;
`endif

    stage2_frame_capture dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .block_size_data(block_size_data), .seq_number_data(seq_number_data),
        .message_number_data(message_number_data), .time_message_data(time_message_data),
        .message_1(message_1), .message_2(message_2), .message_3(message_3),
        .rx_check_sum_data(rx_check_sum_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
`ifdef CHK_RUNNING_EN
        .calc_check_sum_data(calc_check_sum_data), .check_mismatch(check_mismatch),
`endif
        .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [279:0] act, input logic [279:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model of one frame ----------------
    logic [7:0]        fb[$];
    bit                exp_set = 0;
    logic [15:0]       exp_blk;
    logic [31:0]       exp_seq;
    logic [7:0]        exp_num;
    logic [63:0]       exp_tm;
    logic [2:0][279:0] exp_msg;
    logic [7:0]        exp_chk;
    logic [2:0]        exp_err;
    logic [7:0]        exp_sum;

    function automatic logic [7:0] gb(input int i);
        return (i < fb.size()) ? fb[i] : 8'h00;
    endfunction

    // Parse the accepted byte list of a frame by position.
    task automatic model_frame(input bit sop_term);
        int n, slots, chkpos, s;
        n = fb.size();
        exp_blk = {gb(0), gb(1)};
        exp_seq = {gb(2), gb(3), gb(4), gb(5)};
        exp_num = gb(6);
        exp_tm  = {gb(7), gb(8), gb(9), gb(10), gb(11), gb(12), gb(13), gb(14)};
        slots   = (n > 6) ? ((fb[6] > 3) ? 3 : int'(fb[6])) : 0;
        chkpos  = 15 + 35 * slots;
        exp_msg = '0;
        for (int k = 0; k < slots; k++)
            for (int j = 0; j < 35; j++)
                if (15 + 35 * k + j < n) exp_msg[k][8*(34-j) +: 8] = fb[15 + 35*k + j];
        exp_chk = (n > chkpos) ? fb[chkpos] : 8'h00;
        if (n > 6 && fb[6] > 3)                     exp_err = 3'd3;
        else if (sop_term || n <= chkpos)           exp_err = 3'd1;
        else if (n > chkpos + 1)                    exp_err = 3'd2;
        else if (int'(exp_blk) != 13 + 35 * int'(exp_num)) exp_err = 3'd4;
        else                                        exp_err = 3'd0;
        s = 0;
        for (int i = 0; i < n && i < chkpos; i++) s += int'(fb[i]);
        exp_sum = 8'(s);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            if (!exp_set) begin
                check("unexpected_frame", frame_valid, 1'b0);
            end else begin
                check("block_size", block_size_data, exp_blk);
                check("seq_number", seq_number_data, exp_seq);
                check("msg_number", message_number_data, exp_num);
                check("time", time_message_data, exp_tm);
                check("message_1", message_1, exp_msg[0]);
                check("message_2", message_2, exp_msg[1]);
                check("message_3", message_3, exp_msg[2]);
                check("rx_chk", rx_check_sum_data, exp_chk);
                check("err_code", err_code, exp_err);
                check("frame_err", frame_err, exp_err != 3'd0);
                check("in_ready_out", in_ready, 1'b0);
`ifdef CHK_RUNNING_EN
                check("calc_sum", calc_check_sum_data, exp_sum);
                check("mismatch", check_mismatch, exp_sum != exp_chk);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_beat(input logic [7:0] b, input logic s, input logic e);
        in_data = b; in_valid = 1'b1; in_sop = s; in_eop = e;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic build(input logic [15:0] blk, input logic [31:0] seq, input logic [7:0] num,
                         input logic [63:0] tm, input int nmb, input logic [7:0] ck);
        fb.delete();
        for (int i = 1; i >= 0; i--) fb.push_back(blk[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fb.push_back(seq[8*i +: 8]);
        fb.push_back(num);
        for (int i = 7; i >= 0; i--) fb.push_back(tm[8*i +: 8]);
        for (int i = 0; i < nmb; i++) fb.push_back(8'(i));
        fb.push_back(ck);
    endtask

    task automatic truncate(input int n);
        while (fb.size() > n) void'(fb.pop_back());
    endtask

    task automatic send_fb(input bit with_eop);
        for (int i = 0; i < fb.size(); i++) begin
            if (i == fb.size() - 1) check("valid_early", frame_valid, 1'b0);
            drive_beat(fb[i], i == 0, with_eop && (i == fb.size() - 1));
        end
    endtask

    task automatic run_frame(input bit sop_term);
        model_frame(sop_term);
        exp_set = 1;
        send_fb(!sop_term);
        if (sop_term) drive_beat(8'hEE, 1'b1, 1'b0);
        check("latency", frame_valid, 1'b1);
    endtask

    task automatic accept(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_valid", frame_valid, 1'b1);
        end
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        exp_set = 0;
        check("retired", frame_valid, 1'b0);
        check("ready_back", in_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, frame_valid, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_blk"}, block_size_data, 16'h0);
        check({tag, "_seq"}, seq_number_data, 32'h0);
        check({tag, "_num"}, message_number_data, 8'h0);
        check({tag, "_time"}, time_message_data, 64'h0);
        check({tag, "_msg1"}, message_1, 280'h0);
        check({tag, "_chk"}, rx_check_sum_data, 8'h0);
        check({tag, "_err"}, err_code, 3'd0);
        check({tag, "_ferr"}, frame_err, 1'b0);
    endtask

    localparam logic [63:0] TM = 64'h1122334455667788;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // nominal 3-message frame
        build(16'd118, 32'h01020304, 8'd3, TM, 105, 8'h5A);
        run_frame(0);
        check("nom_seq_lit", seq_number_data, 32'h01020304);
        check("nom_time_lit", time_message_data, TM);
        check("nom_m1_b0", message_1[279:272], 8'h00);
        check("nom_m2_b0", message_2[279:272], 8'h23);
        check("nom_m3_last", message_3[7:0], 8'h68);
        check("nom_chk_lit", rx_check_sum_data, 8'h5A);
        check("nom_err_lit", frame_err, 1'b0);
        accept(0);

        // stray non-sop beats in IDLE are dropped
        drive_beat(8'h55, 1'b0, 1'b0);
        drive_beat(8'h66, 1'b0, 1'b1);
        check("stray_dropped", frame_valid, 1'b0);

        // 1-message frame held for 10 cycles
        build(16'd48, 32'hA0B0C0D0, 8'd1, 64'h0102030405060708, 35, 8'h33);
        run_frame(0);
        check("one_m2_lit", message_2, 280'h0);
        check("one_m3_lit", message_3, 280'h0);
        accept(10);

        // eop after 20 bytes
        build(16'd118, 32'h01020304, 8'd3, TM, 105, 8'h5A);
        truncate(20);
        run_frame(0);
        check("short_err_lit", err_code, 3'd1);
        check("short_m1_lit", message_1[279:240], 40'h0001020304);
        check("short_m1_rest", message_1[239:0], 240'h0);
        accept(0);

        // second sop mid-frame, then a clean frame
        build(16'd118, 32'h01020304, 8'd3, TM, 105, 8'h5A);
        truncate(30);
        run_frame(1);
        check("midsop_err_lit", err_code, 3'd1);
        accept(0);
        build(16'd48, 32'hA0B0C0D0, 8'd1, 64'h0102030405060708, 35, 8'h33);
        run_frame(0);
        check("after_sop_err", err_code, 3'd0);
        accept(2);

        // msg_number = 4
        build(16'd153, 32'h0000BEEF, 8'd4, TM, 108, 8'h77);
        run_frame(0);
        check("msgcnt_err_lit", err_code, 3'd3);
        accept(0);

        // block_size mismatch
        build(16'd50, 32'h00000001, 8'd1, TM, 35, 8'h44);
        run_frame(0);
        check("blksz_err_lit", err_code, 3'd4);
        accept(0);

        // two extra bytes after the checksum
        build(16'd48, 32'h00000002, 8'd1, TM, 35, 8'h33);
        fb.push_back(8'hAA);
        fb.push_back(8'hBB);
        run_frame(0);
        check("long_err_lit", err_code, 3'd2);
        check("long_chk_lit", rx_check_sum_data, 8'h33);
        accept(0);

        // reset in the middle of a message
        build(16'd118, 32'h01020304, 8'd3, TM, 105, 8'h5A);
        truncate(40);
        send_fb(0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        rst_n = 1'b1;
        build(16'd118, 32'h01020304, 8'd3, TM, 105, 8'h5A);
        run_frame(0);
        check("post_rst_err", err_code, 3'd0);
        accept(0);

`ifdef CHK_RUNNING_EN
        build(16'd118, 32'h01020304, 8'd3, TM, 105, 8'h3B);
        run_frame(0);
        check("run_calc_lit", calc_check_sum_data, 8'h3B);
        check("run_match_lit", check_mismatch, 1'b0);
        accept(0);
        build(16'd118, 32'h01020304, 8'd3, TM, 105, 8'h3C);
        run_frame(0);
        check("run_flip_lit", check_mismatch, 1'b1);
        accept(0);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
